// File: rtl/wb_sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_sram_pkg
//  Description : Shared sizes and FSM state types for the WB SRAM front end.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_sram_pkg;

   localparam int ADDR_WIDTH = 8;
   localparam int DATA_WIDTH = 32;
   localparam int NUM_WMASKS = 4;

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_CMD  = 2'd1,
      WB_RESP = 2'd2
   } wb_state_e;

   typedef enum logic [1:0] {
      RB_IDLE  = 2'd0,
      RB_ISSUE = 2'd1,
      RB_WAIT  = 2'd2,
      RB_HOLD  = 2'd3
   } rb_state_e;

endpackage
`default_nettype wire

// File: rtl/sram_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : sram_burst_reader
//  Description : Sequential burst-readback engine driving SRAM port 1 and
//                presenting words on a valid/ready stream.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_burst_reader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W:0]   len_i,
   // port-0 write currently on the SRAM pins, and the one about to be driven
   input  logic              p0_wr_cur_i,
   input  logic [ADDR_W-1:0] p0_addr_cur_i,
   input  logic              p0_wr_nxt_i,
   input  logic [ADDR_W-1:0] p0_addr_nxt_i,
   output logic              csb1_o,
   output logic [ADDR_W-1:0] addr1_o,
   input  logic [DATA_W-1:0] dout1_i,
   output logic              busy_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o
);
   import wb_sram_pkg::*;

   localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

   rb_state_e         state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W:0]   rem_q;
   logic              csb1_q;
   logic [ADDR_W-1:0] addr1_q;
   logic              busy_q;
   logic              valid_q;
   logic              last_q;
   logic [DATA_W-1:0] data_q;

   logic [ADDR_W-1:0] ptr_nxt_d;
   logic              coll_ptr_d;
   logic              coll_nxt_d;

   // A read must never share a capture edge with a port-0 write to the same
   // word, otherwise it returns stale data; hold off while such a write is
   // on the pins now or is being launched this cycle.
   always_comb begin
      ptr_nxt_d  = ptr_q + ADDR_W'(1);
      coll_ptr_d = (p0_wr_cur_i && (p0_addr_cur_i == ptr_q)) ||
                   (p0_wr_nxt_i && (p0_addr_nxt_i == ptr_q));
      coll_nxt_d = (p0_wr_cur_i && (p0_addr_cur_i == ptr_nxt_d)) ||
                   (p0_wr_nxt_i && (p0_addr_nxt_i == ptr_nxt_d));
   end

   // Burst FSM; a handshake issues the next read directly to sustain one
   // word every three cycles.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RB_IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         csb1_q  <= 1'b1;
         addr1_q <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         case (state_q)
            RB_IDLE: begin
               if (start_i && (len_i != '0)) begin
                  ptr_q   <= base_i;
                  rem_q   <= len_i;
                  busy_q  <= 1'b1;
                  state_q <= RB_ISSUE;
               end
            end
            RB_ISSUE: begin
               if (!coll_ptr_d) begin
                  csb1_q  <= 1'b0;
                  addr1_q <= ptr_q;
                  state_q <= RB_WAIT;
               end
            end
            RB_WAIT: begin
               csb1_q  <= 1'b1;
               state_q <= RB_HOLD;
            end
            RB_HOLD: begin
               if (!valid_q) begin
                  data_q  <= dout1_i;
                  valid_q <= 1'b1;
                  last_q  <= (rem_q == REM_ONE);
               end else if (ready_i) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  rem_q   <= rem_q - REM_ONE;
                  ptr_q   <= ptr_nxt_d;
                  if (rem_q == REM_ONE) begin
                     busy_q  <= 1'b0;
                     state_q <= RB_IDLE;
                  end else if (!coll_nxt_d) begin
                     csb1_q  <= 1'b0;
                     addr1_q <= ptr_nxt_d;
                     state_q <= RB_WAIT;
                  end else begin
                     state_q <= RB_ISSUE;
                  end
               end
            end
            default: state_q <= RB_IDLE;
         endcase
      end
   end

   assign csb1_o  = csb1_q;
   assign addr1_o = addr1_q;
   assign busy_o  = busy_q;
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;

endmodule
`default_nettype wire

// File: rtl/wb_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wb_sram_ctrl
//  Description : Wishbone slave for a 1RW1R SRAM macro. Port 0 serves single
//                word WB accesses, port 1 feeds a burst readback stream.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_sram_ctrl #(
   parameter int          ADDR_WIDTH = wb_sram_pkg::ADDR_WIDTH,
   parameter int          DATA_WIDTH = wb_sram_pkg::DATA_WIDTH,
   parameter int          NUM_WMASKS = wb_sram_pkg::NUM_WMASKS,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_stb_i,
   input  logic                  wbs_we_i,
   input  logic [NUM_WMASKS-1:0] wbs_sel_i,
   input  logic [31:0]           wbs_adr_i,
   input  logic [DATA_WIDTH-1:0] wbs_dat_i,
   output logic                  wbs_ack_o,
   output logic                  wbs_err_o,
   output logic [DATA_WIDTH-1:0] wbs_dat_o,
   output logic                  csb0,
   output logic                  web0,
   output logic [NUM_WMASKS-1:0] wmask0,
   output logic [ADDR_WIDTH-1:0] addr0,
   output logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] dout0,
   output logic                  csb1,
   output logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] dout1,
   input  logic                  rd_start_i,
   input  logic [ADDR_WIDTH-1:0] rd_base_i,
   input  logic [ADDR_WIDTH:0]   rd_len_i,
   output logic                  rd_busy_o,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_last_o
);
   import wb_sram_pkg::*;

   // lowest byte-address bit above the word index
   localparam int HI = ADDR_WIDTH + 2;

   wb_state_e             state_q;
   logic                  csb0_q;
   logic                  web0_q;
   logic [NUM_WMASKS-1:0] wmask0_q;
   logic [ADDR_WIDTH-1:0] addr0_q;
   logic [DATA_WIDTH-1:0] din0_q;
   logic                  ack_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] dat_q;

   logic                  req_d;
   logic                  hit_d;
   logic                  wr_nxt_d;
   logic                  wr_cur_d;
   logic [ADDR_WIDTH-1:0] word_d;

   // Request decode; byte-offset bits of the address are don't-care.
   always_comb begin
      req_d    = wbs_cyc_i && wbs_stb_i;
      hit_d    = (wbs_adr_i[31:HI] == BASE_ADDR[31:HI]);
      word_d   = wbs_adr_i[HI-1:2];
      wr_nxt_d = (state_q == WB_IDLE) && req_d && hit_d && wbs_we_i;
      wr_cur_d = !csb0_q && !web0_q;
   end

   // WB FSM: launch the SRAM access, let the macro answer, then ack.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q  <= WB_IDLE;
         csb0_q   <= 1'b1;
         web0_q   <= 1'b1;
         wmask0_q <= '0;
         addr0_q  <= '0;
         din0_q   <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            WB_IDLE: begin
               if (req_d) begin
                  if (hit_d) begin
                     csb0_q   <= 1'b0;
                     web0_q   <= !wbs_we_i;
                     wmask0_q <= wbs_sel_i;
                     addr0_q  <= word_d;
                     din0_q   <= wbs_dat_i;
                     state_q  <= WB_CMD;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            WB_CMD: begin
               csb0_q  <= 1'b1;
               state_q <= WB_RESP;
            end
            WB_RESP: begin
               // web0 still reflects the access just completed
               if (web0_q) begin
                  dat_q <= dout0;
               end
               ack_q   <= 1'b1;
               state_q <= WB_IDLE;
            end
            default: state_q <= WB_IDLE;
         endcase
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_err_o = err_q;
   assign wbs_dat_o = dat_q;
   assign csb0      = csb0_q;
   assign web0      = web0_q;
   assign wmask0    = wmask0_q;
   assign addr0     = addr0_q;
   assign din0      = din0_q;

   sram_burst_reader #(
      .ADDR_W (ADDR_WIDTH),
      .DATA_W (DATA_WIDTH)
   ) u_reader (
      .clk_i         (wb_clk_i),
      .rst_ni        (wb_rst_n),
      .start_i       (rd_start_i),
      .base_i        (rd_base_i),
      .len_i         (rd_len_i),
      .p0_wr_cur_i   (wr_cur_d),
      .p0_addr_cur_i (addr0_q),
      .p0_wr_nxt_i   (wr_nxt_d),
      .p0_addr_nxt_i (word_d),
      .csb1_o        (csb1),
      .addr1_o       (addr1),
      .dout1_i       (dout1),
      .busy_o        (rd_busy_o),
      .valid_o       (rd_valid_o),
      .ready_i       (rd_ready_i),
      .data_o        (rd_data_o),
      .last_o        (rd_last_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_sram_ctrl
//  Description : Self-checking bench for wb_sram_ctrl with an SRAM macro model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_sram_ctrl;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o, wbs_err_o;
   logic [31:0] wbs_dat_o;
   logic        csb0, web0, csb1;
   logic [3:0]  wmask0;
   logic [7:0]  addr0, addr1;
   logic [31:0] din0, dout0, dout1;
   logic        rd_start_i;
   logic [7:0]  rd_base_i;
   logic [8:0]  rd_len_i;
   logic        rd_busy_o, rd_valid_o, rd_ready_i, rd_last_o;
   logic [31:0] rd_data_o;

   always #5 clk = ~clk;

   wb_sram_ctrl dut (
      .wb_clk_i(clk), .wb_rst_n(rst_n),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
      .dout0(dout0), .csb1(csb1), .addr1(addr1), .dout1(dout1),
      .rd_start_i(rd_start_i), .rd_base_i(rd_base_i), .rd_len_i(rd_len_i),
      .rd_busy_o(rd_busy_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
      .rd_data_o(rd_data_o), .rd_last_o(rd_last_o)
   );

   // ---------------- SRAM macro model: capture on posedge, drive on negedge
   logic [31:0] mem [0:255];
   logic [31:0] r0, r1;
   always @(posedge clk) begin
      if (!csb1) r1 <= mem[addr1];
      if (!csb0) begin
         if (web0) r0 <= mem[addr0];
         else for (int b = 0; b < 4; b++)
            if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
      end
   end
   always @(negedge clk) begin
      dout0 <= r0;
      dout1 <= r1;
   end

   // ---------------- ready pattern: 0 always, 1 toggle, 2 held low
   int   ready_mode;
   logic tog = 1'b0;
   always @(posedge clk) tog <= ~tog;
   assign rd_ready_i = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? tog : 1'b0;

   // ---------------- behavioural model / expectations
   int          cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] model [0:255];
   int          exp_ack_cyc = -10, exp_err_cyc = -10, exp_cs_cyc = -10;
   logic        exp_we, exp_is_rd;
   int          exp_addr;
   logic [3:0]  exp_sel;
   logic [31:0] exp_din, exp_rdata;
   logic [31:0] exp_dat = 32'h0;
   logic [32:0] exp_q [$];
   logic [31:0] log_d [0:15];
   int          log_c [0:15];
   int          n_log = 0;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- compare process
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_dat = 32'h0;
      end else begin
         check("wbs_ack_o", 32'(wbs_ack_o), 32'(cyc == exp_ack_cyc));
         check("wbs_err_o", 32'(wbs_err_o), 32'(cyc == exp_err_cyc));
         check("csb0", 32'(csb0), 32'(cyc != exp_cs_cyc));
         if (cyc == exp_cs_cyc) begin
            check("web0", 32'(web0), 32'(!exp_we));
            check("addr0", 32'(addr0), 32'(exp_addr));
            if (exp_we) begin
               check("wmask0", 32'(wmask0), 32'(exp_sel));
               check("din0", din0, exp_din);
            end
         end
         if (cyc == exp_ack_cyc && exp_is_rd) exp_dat = exp_rdata;
         check("wbs_dat_o", wbs_dat_o, exp_dat);
         check("rd_busy_o", 32'(rd_busy_o), 32'(exp_q.size() != 0));
         if (rd_valid_o) begin
            if (exp_q.size() == 0) begin
               check("rd_valid_o_spurious", 32'(rd_valid_o), 32'h0);
            end else begin
               check("rd_data_o", rd_data_o, exp_q[0][31:0]);
               check("rd_last_o", 32'(rd_last_o), 32'(exp_q[0][32]));
               if (rd_ready_i) begin
                  if (n_log < 16) begin
                     log_d[n_log] = rd_data_o;
                     log_c[n_log] = cyc;
                  end
                  n_log++;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers (all entered #1 after a posedge)
   task automatic wb_xfer(input logic we, input logic [31:0] adr,
                          input logic [3:0] sel, input logic [31:0] dat);
      logic hit;
      int   s, idx;
      hit = ((adr >> 10) == (BASE >> 10));
      idx = int'((adr - BASE) >> 2);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
      @(posedge clk); #1;
      s = cyc;
      if (hit) begin
         exp_cs_cyc = s; exp_we = we; exp_addr = idx; exp_sel = sel; exp_din = dat;
         exp_ack_cyc = s + 2;
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (sel[b]) model[idx][8*b +: 8] = dat[8*b +: 8];
            exp_is_rd = 1'b0;
         end else begin
            exp_is_rd = 1'b1;
            exp_rdata = model[idx];
         end
         repeat (2) @(posedge clk);
         @(negedge clk);
      end else begin
         exp_err_cyc = s;
         @(negedge clk);
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic burst_start(input logic [7:0] base, input logic [8:0] len, output int s);
      rd_start_i = 1'b1; rd_base_i = base; rd_len_i = len;
      @(posedge clk); #1;
      rd_start_i = 1'b0;
      s = cyc;
      for (int i = 0; i < int'(len); i++)
         exp_q.push_back({1'(i == int'(len) - 1), model[(int'(base) + i) % 256]});
   endtask

   task automatic burst_wait(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         check("burst_timeout", 32'(exp_q.size()), 32'h0);
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic clear_log();
      n_log = 0;
      for (int i = 0; i < 16; i++) begin
         log_d[i] = 32'h0;
         log_c[i] = 0;
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_csb0"},   32'(csb0), 32'h1);
      check({tag, "_web0"},   32'(web0), 32'h1);
      check({tag, "_csb1"},   32'(csb1), 32'h1);
      check({tag, "_wmask0"}, 32'(wmask0), 32'h0);
      check({tag, "_addr0"},  32'(addr0), 32'h0);
      check({tag, "_din0"},   din0, 32'h0);
      check({tag, "_addr1"},  32'(addr1), 32'h0);
      check({tag, "_ack"},    32'(wbs_ack_o), 32'h0);
      check({tag, "_err"},    32'(wbs_err_o), 32'h0);
      check({tag, "_dat_o"},  wbs_dat_o, 32'h0);
      check({tag, "_busy"},   32'(rd_busy_o), 32'h0);
      check({tag, "_valid"},  32'(rd_valid_o), 32'h0);
      check({tag, "_last"},   32'(rd_last_o), 32'h0);
      check({tag, "_rdata"},  rd_data_o, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence
   initial begin
      int s, k;
      rst_n = 1'b0;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
      rd_start_i = 1'b0; rd_base_i = 8'h0; rd_len_i = 9'h0;
      ready_mode = 0;
      for (int i = 0; i < 256; i++) model[i] = 32'h0;
      clear_log();
      repeat (3) @(posedge clk);
      #1;
      check_reset("por");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // full write then read back
      wb_xfer(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF);
      wb_xfer(1'b0, 32'h3000_0010, 4'h0, 32'h0);
      check("read_deadbeef", wbs_dat_o, 32'hDEAD_BEEF);

      // single byte lane merge
      wb_xfer(1'b1, 32'h3000_0010, 4'b0010, 32'h0000_5500);
      wb_xfer(1'b0, 32'h3000_0010, 4'h0, 32'h0);
      check("read_bytemask", wbs_dat_o, 32'hDEAD_55EF);

      // byte offset ignored; window misses above and below
      wb_xfer(1'b0, 32'h3000_0013, 4'h0, 32'h0);
      check("read_offset", wbs_dat_o, 32'hDEAD_55EF);
      wb_xfer(1'b1, 32'h3000_0400, 4'hF, 32'h1111_1111);
      wb_xfer(1'b0, 32'h2FFF_FFFC, 4'h0, 32'h0);
      check("miss_keeps_dat", wbs_dat_o, 32'hDEAD_55EF);

      // preload wrap-around region and a few more words
      wb_xfer(1'b1, 32'h3000_03F8, 4'hF, 32'h1);
      wb_xfer(1'b1, 32'h3000_03FC, 4'hF, 32'h2);
      wb_xfer(1'b1, 32'h3000_0000, 4'hF, 32'h3);
      wb_xfer(1'b1, 32'h3000_0004, 4'hF, 32'hA1);
      wb_xfer(1'b1, 32'h3000_0008, 4'hF, 32'hA2);
      wb_xfer(1'b1, 32'h3000_000C, 4'hF, 32'hA3);

      // burst across 255 -> 0 at full throughput
      clear_log();
      burst_start(8'd254, 9'd3, s);
      burst_wait(40);
      check("burst1_count", 32'(n_log), 32'd3);
      check("burst1_w0", log_d[0], 32'h1);
      check("burst1_w1", log_d[1], 32'h2);
      check("burst1_w2", log_d[2], 32'h3);
      check("burst1_lat", 32'(log_c[0] - s), 32'd3);
      check("burst1_rate01", 32'(log_c[1] - log_c[0]), 32'd3);
      check("burst1_rate12", 32'(log_c[2] - log_c[1]), 32'd3);

      // back-pressure
      clear_log();
      ready_mode = 1;
      burst_start(8'd0, 9'd5, s);
      burst_wait(80);
      ready_mode = 0;
      check("burst2_count", 32'(n_log), 32'd5);
      check("burst2_w4", log_d[4], 32'hDEAD_55EF);

      // zero length is a no-op
      rd_start_i = 1'b1; rd_base_i = 8'd7; rd_len_i = 9'd0;
      @(posedge clk); #1;
      rd_start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // start while busy is ignored
      clear_log();
      burst_start(8'd1, 9'd2, s);
      rd_start_i = 1'b1; rd_base_i = 8'd100; rd_len_i = 9'd7;
      @(posedge clk); #1;
      rd_start_i = 1'b0;
      burst_wait(40);
      check("busy_ign_count", 32'(n_log), 32'd2);
      check("busy_ign_w1", log_d[1], 32'hA2);

      // read racing a port-0 write to the same word sees the new data
      wb_xfer(1'b1, 32'h3000_0080, 4'hF, 32'h0BAD_0BAD);
      clear_log();
      model[32] = 32'h1234_5678;
      burst_start(8'd32, 9'd1, s);
      wb_xfer(1'b1, 32'h3000_0080, 4'hF, 32'h1234_5678);
      burst_wait(40);
      check("collide_count", 32'(n_log), 32'd1);
      check("collide_data", log_d[0], 32'h1234_5678);

      // reset with burst in HOLD and WB in CMD
      ready_mode = 2;
      burst_start(8'd254, 9'd2, s);
      k = 0;
      while (!rd_valid_o && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("hold_reached", 32'(rd_valid_o), 32'h1);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      wbs_adr_i = 32'h3000_0000; wbs_sel_i = 4'h0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_q.delete();
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      #1;
      check_reset("midrst");
      repeat (2) @(posedge clk);
      #1;
      ready_mode = 0;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("post_rst_valid", 32'(rd_valid_o), 32'h0);
      check("post_rst_dat", wbs_dat_o, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
